// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: bus width constants plus the memory arbiter's state and grant-owner types.
package mem_arbiter_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned WSTRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  // Data side wins a tie unless it also won the previous completed grant.
  function automatic owner_e pick_owner(input logic if_req, input logic d_req, input owner_e last);
    if (if_req && d_req) begin
      return (last == OWNER_D) ? OWNER_I : OWNER_D;
    end
    return d_req ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single req/ack memory bus, with a per-transaction
// busy timeout that completes the stalled port with all-ones data and sets a sticky err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [WSTRB_W-1:0]  d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,

  output logic                mem_req,
  output logic                mem_we,
  output logic [WSTRB_W-1:0]  mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,

  output logic                stall_if,
  output logic                stall_mem,
  output logic                err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e          state_q;
  owner_e              last_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [WSTRB_W-1:0]  mem_wstrb_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                if_ready_q;
  logic                d_ready_q;
  logic                err_q;

  owner_e              grant_c;
  logic                expire_c;
  logic                done_c;
  logic [DATA_W-1:0]   resp_data_c;

  assign grant_c     = pick_owner(if_req, d_req, last_q);
  // This busy cycle is the TIMEOUT-th without an acknowledge.
  assign expire_c    = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign done_c      = mem_ack || expire_c;
  assign resp_data_c = mem_ack ? mem_rdata : '1;

  // Arbitration FSM; every bus-facing output comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= OWNER_I;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (if_req || d_req) begin
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            if (grant_c == OWNER_D) begin
              state_q     <= BUSY_D;
              mem_we_q    <= d_we;
              mem_wstrb_q <= d_wstrb;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
            end else begin
              state_q     <= BUSY_I;
              mem_we_q    <= 1'b0;
              mem_wstrb_q <= '0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (done_c) begin
            // An ack in the expiring cycle is a normal completion.
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            if (!mem_ack) begin
              err_q <= 1'b1;
              cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_q == BUSY_D) begin
              last_q    <= OWNER_D;
              d_ready_q <= 1'b1;
              d_rdata_q <= resp_data_c;
            end else begin
              last_q     <= OWNER_I;
              if_ready_q <= 1'b1;
              if_rdata_q <= resp_data_c;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign err       = err_q;

  // Pipeline stalls are combinational so the core freezes in the request cycle itself.
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory responder with programmable wait states and a
// scoreboard of expected completions checked whenever a ready pulse appears.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 15;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_wstrb;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stall_if;
  logic              stall_mem;
  logic              err;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              is_d;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic resp_en;
  logic force_ack;
  int   resp_wait;
  int   resp_cnt = 0;

  function automatic logic [DATA_W-1:0] mem_model(input logic [ADDR_W-1:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic is_d, input logic [DATA_W-1:0] d);
    exp_q.push_back({is_d, d});
  endtask

  // Steps until the port's ready pulse, counting cycles with mem_req high on the way.
  task automatic run_until_ready(input logic is_d, input string tag, output int busy);
    logic found;
    found = 1'b0;
    busy  = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (is_d ? d_ready : if_ready) found = 1'b1;
      else if (mem_req) busy++;
    end
    chk(tag, 64'(found), 64'(1'b1));
  endtask

  // Memory responder: acks after resp_wait busy cycles; force_ack injects stray acks.
  always @(negedge clk) begin
    if (resp_en && mem_req) begin
      mem_ack = (resp_cnt == resp_wait);
      resp_cnt++;
    end else begin
      mem_ack  = force_ack;
      resp_cnt = 0;
    end
    mem_rdata = mem_model(mem_addr);
  end

  // Scoreboard: every ready pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (rst_n && (if_ready || d_ready)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 64'({if_ready, d_ready}), 64'(2'b00));
      end else begin
        mon_e = exp_q.pop_front();
        chk("ready_port", 64'({if_ready, d_ready}), 64'(mon_e.is_d ? 2'b01 : 2'b10));
        chk("ready_data", 64'(mon_e.is_d ? d_rdata : if_rdata), 64'(mon_e.rdata));
      end
    end
  end

  initial begin
    int busy;
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    resp_en = 1'b0; resp_wait = 0; force_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'(1'b0));
    chk("rst_mem_ctl", 64'({mem_we, mem_wstrb}), 64'(5'b0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(32'h0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(32'h0));
    chk("rst_ready", 64'({if_ready, d_ready}), 64'(2'b00));
    chk("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    chk("rst_err", 64'(err), 64'(1'b0));
    rst_n = 1'b1;
    step();

    // Single fetch, zero wait states.
    resp_en = 1'b1; resp_wait = 0;
    if_addr = 32'h100; if_req = 1'b1;
    push_exp(1'b0, 32'h0050_0093);
    #1 chk("fetch_stall_c0", 64'(stall_if), 64'(1'b1));
    step();
    chk("fetch_req_c1", 64'(mem_req), 64'(1'b1));
    chk("fetch_addr_c1", 64'(mem_addr), 64'(32'h100));
    chk("fetch_we_c1", 64'({mem_we, mem_wstrb}), 64'(5'b0));
    chk("fetch_stall_c1", 64'(stall_if), 64'(1'b1));
    step();
    chk("fetch_ready_c2", 64'(if_ready), 64'(1'b1));
    chk("fetch_rdata_c2", 64'(if_rdata), 64'(32'h0050_0093));
    chk("fetch_stall_c2", 64'(stall_if), 64'(1'b0));
    chk("fetch_req_c2", 64'(mem_req), 64'(1'b0));
    if_req = 1'b0;
    step();
    chk("fetch_pulse_once", 64'(if_ready), 64'(1'b0));

    // Data write with three wait states: bus held stable for four cycles.
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hCAFE;
    resp_wait = 3;
    push_exp(1'b1, mem_model(32'h2000));
    #1 chk("wr_stall_c0", 64'(stall_mem), 64'(1'b1));
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("wr_req_held", 64'(mem_req), 64'(1'b1));
      chk("wr_addr_held", 64'(mem_addr), 64'(32'h2000));
      chk("wr_ctl_held", 64'({mem_we, mem_wstrb, mem_wdata}), 64'({1'b1, 4'b0011, 32'hCAFE}));
      chk("wr_stall_held", 64'(stall_mem), 64'(1'b1));
    end
    step();
    chk("wr_ready", 64'(d_ready), 64'(1'b1));
    chk("wr_stall_release", 64'(stall_mem), 64'(1'b0));
    chk("wr_req_drop", 64'(mem_req), 64'(1'b0));
    d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'b0;
    step();
    chk("wr_pulse_once", 64'(d_ready), 64'(1'b0));
    chk("if_rdata_hold", 64'(if_rdata), 64'(32'h0050_0093));

    // Stray acknowledge while idle is ignored.
    force_ack = 1'b1;
    step();
    step();
    force_ack = 1'b0;
    chk("stray_ack_req", 64'(mem_req), 64'(1'b0));
    chk("stray_ack_ready", 64'({if_ready, d_ready}), 64'(2'b00));
    if_addr = 32'h140; if_req = 1'b1; resp_wait = 1;
    push_exp(1'b0, mem_model(32'h140));
    run_until_ready(1'b0, "fetch2_seen", busy);
    chk("fetch2_busy", 64'(busy), 64'(2));
    if_req = 1'b0;
    step();

    // Both requesting continuously: D, I, D, I (last completed grant was I).
    resp_wait = 0; if_addr = 32'h100; d_addr = 32'h3000;
    push_exp(1'b1, mem_model(32'h3000));
    push_exp(1'b0, 32'h0050_0093);
    push_exp(1'b1, mem_model(32'h3000));
    push_exp(1'b0, 32'h0050_0093);
    if_req = 1'b1; d_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c % 2 == 1) begin
        chk("alt_req", 64'(mem_req), 64'(1'b1));
        chk("alt_addr", 64'(mem_addr), 64'((c % 4 == 1) ? 32'h3000 : 32'h100));
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    step();

    // Ack in the very cycle the timeout would expire wins.
    resp_wait = int'(TIMEOUT) - 1; d_addr = 32'h7000; d_req = 1'b1;
    push_exp(1'b1, mem_model(32'h7000));
    run_until_ready(1'b1, "ackto_seen", busy);
    chk("ackto_busy", 64'(busy), 64'(TIMEOUT));
    chk("ackto_err", 64'(err), 64'(1'b0));
    d_req = 1'b0;
    step();

    // Request withdrawn mid-transaction still completes.
    resp_wait = 2; d_addr = 32'h5000; d_req = 1'b1;
    push_exp(1'b1, mem_model(32'h5000));
    step();
    d_req = 1'b0;
    #1 chk("drop_stall", 64'(stall_mem), 64'(1'b0));
    run_until_ready(1'b1, "drop_seen", busy);
    chk("drop_busy", 64'(busy), 64'(2));
    step();
    chk("drop_no_regrant", 64'(mem_req), 64'(1'b0));

    // Reset in BUSY_D abandons the transaction, then it is re-arbitrated.
    resp_en = 1'b0; d_addr = 32'h4000; d_req = 1'b1;
    step();
    step();
    chk("rst_mid_busy", 64'(mem_req), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 64'(mem_req), 64'(1'b0));
    chk("rst_mid_ready", 64'(d_ready), 64'(1'b0));
    @(posedge clk);
    #1;
    chk("rst_mid_noready", 64'(d_ready), 64'(1'b0));
    rst_n = 1'b1; resp_en = 1'b1; resp_wait = 0;
    push_exp(1'b1, mem_model(32'h4000));
    run_until_ready(1'b1, "rst_regrant_seen", busy);
    chk("rst_regrant_busy", 64'(busy), 64'(1));
    d_req = 1'b0;
    step();

    // No acknowledge: timeout after TIMEOUT busy cycles, err sticky.
    resp_en = 1'b0; d_addr = 32'h6000; d_req = 1'b1;
    push_exp(1'b1, 32'hFFFF_FFFF);
    run_until_ready(1'b1, "timeout_seen", busy);
    chk("timeout_busy", 64'(busy), 64'(TIMEOUT));
    chk("timeout_req", 64'(mem_req), 64'(1'b0));
    chk("timeout_err", 64'(err), 64'(1'b1));
    d_req = 1'b0;
    repeat (3) step();
    chk("err_sticky_idle", 64'(err), 64'(1'b1));
    resp_en = 1'b1; resp_wait = 0; if_addr = 32'h100; if_req = 1'b1;
    push_exp(1'b0, 32'h0050_0093);
    run_until_ready(1'b0, "post_to_seen", busy);
    chk("err_sticky_txn", 64'(err), 64'(1'b1));
    if_req = 1'b0;
    step();
    step();

    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning maximum number of busy cycles waiting for an acknowledge.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have instruction-fetch ports:
- if_req, input, 1 bit.
- if_addr, input, ADDR_W bits.
- if_rdata, output, DATA_W bits.
- if_ready, output, 1 bit.
REQ-007 SHALL have data-access ports:
- d_req, input, 1 bit.
- d_we, input, 1 bit.
- d_wstrb, input, 4 bits.
- d_addr, input, ADDR_W bits.
- d_wdata, input, DATA_W bits.
- d_rdata, output, DATA_W bits.
- d_ready, output, 1 bit.
REQ-008 SHALL have memory-side ports:
- mem_req, output, 1 bit.
- mem_we, output, 1 bit.
- mem_wstrb, output, 4 bits.
- mem_addr, output, ADDR_W bits.
- mem_wdata, output, DATA_W bits.
- mem_rdata, input, DATA_W bits.
- mem_ack, input, 1 bit.
REQ-009 SHALL have port stall_if, output, 1 bit: freeze PC and IF/ID.
REQ-010 SHALL have port stall_mem, output, 1 bit: freeze the whole pipeline.
REQ-011 SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-012 SHALL implement an FSM with states IDLE, BUSY_I and BUSY_D.
REQ-013 In IDLE with exactly one request pending, SHALL grant that requester.
REQ-014 In IDLE, SHALL register the granted requester's address, write enable, strobes and write data into the mem_* output registers.
REQ-015 In IDLE, SHALL move to BUSY_I (fetch grant) or BUSY_D (data grant) on the next edge.
REQ-016 SHALL drive mem_we=0 and mem_wstrb=0 for fetch grants.
REQ-017 With both requests pending in IDLE, SHALL grant D unless the last completed grant was D, in which case I is granted; the last-grant bit resets to I.
REQ-018 SHALL hold mem_req=1 and all mem_* outputs constant throughout BUSY_x until mem_ack=1.
REQ-019 On mem_ack in BUSY_x, SHALL capture mem_rdata into x_rdata and pulse x_ready for exactly one cycle (registered).
REQ-020 On mem_ack in BUSY_x, SHALL deassert mem_req and return to IDLE on the same edge.
REQ-021 Minimum latency SHALL be: request sampled at cycle 0, mem_req high at cycle 1, ack at cycle 1, x_ready high at cycle 2.
REQ-022 A new grant SHALL be possible at the earliest in the cycle x_ready is high (IDLE evaluation), giving one transaction per two cycles.
REQ-023 x_rdata SHALL hold its last captured value until the next completion for that port.
REQ-024 Deassertion of x_req during BUSY_x SHALL NOT abort the transaction; it completes and x_ready still pulses.
REQ-025 mem_ack received in IDLE SHALL be ignored.
REQ-026 A busy-cycle counter SHALL clear on entry to BUSY_x and increment each BUSY cycle without ack.
REQ-027 When the counter reaches TIMEOUT, SHALL drop mem_req, pulse x_ready with x_rdata=all-ones, set err, and return to IDLE.
REQ-028 mem_ack arriving in the same cycle as the timeout SHALL take precedence: a normal completion with no err.
REQ-029 stall_if SHALL equal if_req & ~if_ready (combinational).
REQ-030 stall_mem SHALL equal d_req & ~d_ready (combinational).

Reset
REQ-031 On rst_n=0, asynchronously, SHALL set:
- state IDLE.
- mem_req, mem_we, if_ready, d_ready and err to 0.
- mem_wstrb 0; mem_addr, mem_wdata, if_rdata and d_rdata all 0.
- counter 0; last-grant bit I.
REQ-032 Reset asserted mid-transaction SHALL abandon it with no ready pulse; after release the FSM re-arbitrates any still-pending requests.
REQ-033 err SHALL clear only on reset.

Structure
REQ-034 The state enum (IDLE, BUSY_I, BUSY_D) and grant-owner enum SHALL live in the shared CPU package beside the existing width constants.
REQ-035 SHALL be a single module with no sub-modules; the timeout counter SHALL be $clog2(TIMEOUT+1) bits wide.

Verification
REQ-036 Single fetch: if_req=1, if_addr=0x100, ack one cycle after mem_req, mem_rdata=0x00500093 -> mem_addr=0x100 and mem_we=0 at cycle 1; if_ready=1 and if_rdata=0x00500093 at cycle 2; stall_if=1 at cycles 0-1.
REQ-037 Simultaneous requests: if_req=d_req=1 continuously, immediate acks -> grant order D, I, D, I; mem_addr alternates between d_addr and if_addr.
REQ-038 Data write: d_req=1, d_we=1, d_wstrb=4'b0011, d_addr=0x2000, d_wdata=0xCAFE, ack after 3 wait cycles -> mem_* outputs held stable 4 cycles; d_ready pulses once; stall_mem=1 until then.
REQ-039 Timeout: d_req=1, no ack -> after TIMEOUT=15 busy cycles, mem_req=0, d_ready=1, d_rdata=0xFFFFFFFF, err=1; err stays 1.
REQ-040 Reset mid-BUSY_D: rst_n=0 for 1 cycle -> mem_req=0 immediately; no d_ready pulse; a new transaction starts after release.
REQ-041 Ack with timeout: mem_ack asserted in the same cycle the counter hits TIMEOUT -> normal completion; err stays 0.
